// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Hits are served combinationally; misses stall while a dirty victim is evicted and the line refilled.
module dcache_controller #(
   parameter int NUM_LINES = 16,
   parameter int LINE_BITS = 256,
   parameter int ADDR_W    = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_req_i,
   input  logic                 cpu_we_i,
   input  logic [ADDR_W-1:0]    cpu_addr_i,
   input  logic [31:0]          cpu_data_i,
   output logic [31:0]          cpu_data_o,
   output logic                 cpu_stall_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i
);
   localparam int OFF_W  = $clog2(LINE_BITS / 8);
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
   localparam int WORDS  = LINE_BITS / 32;
   localparam int WSEL_W = $clog2(WORDS);

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

   state_t               state_q;
   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_BITS-1:0] data_q [NUM_LINES];
   logic [ADDR_W-1:0]    miss_addr_q;
   logic                 mem_req_q;
   logic                 mem_we_q;
   logic [ADDR_W-1:0]    mem_addr_q;
   logic [LINE_BITS-1:0] mem_data_q;

   logic [TAG_W-1:0]     req_tag;
   logic [TAG_W-1:0]     miss_tag;
   logic [IDX_W-1:0]     req_idx;
   logic [IDX_W-1:0]     miss_idx;
   logic [WSEL_W-1:0]    req_wsel;
   logic [LINE_BITS-1:0] req_line;
   logic [LINE_BITS-1:0] store_line;
   logic [31:0]          req_words [WORDS];
   logic                 hit;
   logic                 idle_hit;
   logic                 store_hit;
   logic                 refill_done;
   logic                 unused_bits;

   assign req_tag  = cpu_addr_i[ADDR_W-1 -: TAG_W];
   assign req_idx  = cpu_addr_i[OFF_W +: IDX_W];
   assign req_wsel = cpu_addr_i[2 +: WSEL_W];
   assign miss_tag = miss_addr_q[ADDR_W-1 -: TAG_W];
   assign miss_idx = miss_addr_q[OFF_W +: IDX_W];
   assign req_line = data_q[req_idx];

   assign hit         = cpu_req_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
   assign idle_hit    = (state_q == IDLE) & hit;
   assign store_hit   = idle_hit & cpu_we_i;
   assign refill_done = (state_q == REFILL) & mem_ack_i;

   // Split the indexed line into words for load select and store merge.
   for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
      assign req_words[gi] = req_line[gi*32 +: 32];
      assign store_line[gi*32 +: 32] = (req_wsel == WSEL_W'(gi)) ? cpu_data_i : req_line[gi*32 +: 32];
   end

   assign cpu_stall_o = cpu_req_i & ~idle_hit;
   assign cpu_data_o  = (idle_hit & ~cpu_we_i) ? req_words[req_wsel] : 32'd0;

   assign mem_req_o  = mem_req_q;
   assign mem_we_o   = mem_we_q;
   assign mem_addr_o = mem_addr_q;
   assign mem_data_o = mem_data_q;

   assign unused_bits = ^{cpu_addr_i[1:0], miss_addr_q[OFF_W-1:0]};

   // Tag and data need no reset: valid gates every use of them.
   always_ff @(posedge clk_i) begin
      if (refill_done) begin
         data_q[miss_idx] <= mem_data_i;
         tag_q[miss_idx]  <= miss_tag;
      end else if (store_hit) begin
         data_q[req_idx] <= store_line;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         miss_addr_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
      end else begin
         if (store_hit) begin
            dirty_q[req_idx] <= 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (cpu_req_i && !hit) begin
                  miss_addr_q <= cpu_addr_i;
                  mem_req_q   <= 1'b1;
                  if (valid_q[req_idx] && dirty_q[req_idx]) begin
                     state_q    <= WRITEBACK;
                     mem_we_q   <= 1'b1;
                     mem_addr_q <= {tag_q[req_idx], req_idx, {OFF_W{1'b0}}};
                     mem_data_q <= req_line;
                  end else begin
                     state_q    <= REFILL;
                     mem_we_q   <= 1'b0;
                     mem_addr_q <= {req_tag, req_idx, {OFF_W{1'b0}}};
                  end
               end
            end
            WRITEBACK: begin
               // Refill address comes from the latched miss, never the live CPU address.
               if (mem_ack_i) begin
                  state_q    <= REFILL;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= {miss_tag, miss_idx, {OFF_W{1'b0}}};
               end
            end
            REFILL: begin
               if (mem_ack_i) begin
                  state_q           <= IDLE;
                  mem_req_q         <= 1'b0;
                  valid_q[miss_idx] <= 1'b1;
                  dirty_q[miss_idx] <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: expected memory transactions and load data
// are queued when an access is issued and checked as the cache produces them.
module tb_dcache_controller;
   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         cpu_req_i;
   logic         cpu_we_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_data_i;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic         mem_req_o;
   logic         mem_we_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      int          widx;
      logic [31:0] word;
   } mem_txn_t;

   mem_txn_t     exp_mem_q[$];
   logic [31:0]  exp_load_q[$];
   logic [255:0] mem_model [logic [31:0]];
   int           checks = 0;
   int           errors = 0;

   always #5 clk_i = ~clk_i;

   dcache_controller dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .cpu_req_i  (cpu_req_i),
      .cpu_we_i   (cpu_we_i),
      .cpu_addr_i (cpu_addr_i),
      .cpu_data_i (cpu_data_i),
      .cpu_data_o (cpu_data_o),
      .cpu_stall_o(cpu_stall_o),
      .mem_req_o  (mem_req_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_data_o (mem_data_o),
      .mem_data_i (mem_data_i),
      .mem_ack_i  (mem_ack_i)
   );

   function automatic logic [255:0] pat_line(input logic [31:0] base);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = (base + 32'(w * 4)) ^ 32'hA5A5_0000;
      return l;
   endfunction

   function automatic logic [255:0] get_line(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return pat_line(a);
   endfunction

   function automatic mem_txn_t txn(input logic we, input logic [31:0] a, input int widx, input logic [31:0] w);
      mem_txn_t t;
      t.we = we; t.addr = a; t.widx = widx; t.word = w;
      return t;
   endfunction

   // Issue one CPU access, serve memory with n-cycle latency, check stall length and load data.
   task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int n, input int exp_stall);
      int       stall_cyc = 0;
      int       req_cnt   = 0;
      bit       done      = 0;
      mem_txn_t t;
      logic [31:0] exp_w;
      cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wdata;
      for (int g = 0; g < 200 && !done; g++) begin
         @(negedge clk_i);
         if (!cpu_stall_o) begin
            done = 1;
         end else begin
            stall_cyc++;
            if (mem_req_o) begin
               req_cnt++;
               if (req_cnt == n) begin
                  if (exp_mem_q.size() == 0) begin
                     errors++;
                     $display("FAIL mem_txn unexpected: we=%0b addr=%h, required no transaction", mem_we_o, mem_addr_o);
                  end else begin
                     t = exp_mem_q.pop_front();
                     checks++;
                     if (mem_we_o !== t.we || mem_addr_o !== t.addr) begin
                        errors++;
                        $display("FAIL mem_txn: got we=%0b addr=%h, required we=%0b addr=%h", mem_we_o, mem_addr_o, t.we, t.addr);
                     end
                     if (t.we) begin
                        checks++;
                        if (mem_data_o[t.widx*32 +: 32] !== t.word) begin
                           errors++;
                           $display("FAIL evict_word%0d: got %h, required %h", t.widx, mem_data_o[t.widx*32 +: 32], t.word);
                        end
                     end
                  end
                  if (mem_we_o) mem_model[mem_addr_o] = mem_data_o;
                  else mem_data_i = get_line(mem_addr_o);
                  mem_ack_i = 1'b1;
                  req_cnt = 0;
               end
            end
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
         end
      end
      $display("access we=%0b addr=%h stall=%0d data_o=%h", we, addr, stall_cyc, cpu_data_o);
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL timeout addr=%h: stall still %0b after 200 cycles, required 0", addr, cpu_stall_o);
      end else begin
         checks++;
         if (stall_cyc != exp_stall) begin
            errors++;
            $display("FAIL stall_len addr=%h: got %0d, required %0d", addr, stall_cyc, exp_stall);
         end
         checks++;
         if (mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL mem_req_after addr=%h: got %0b, required 0", addr, mem_req_o);
         end
         if (!we) begin
            exp_w = exp_load_q.pop_front();
            if (cpu_data_o !== exp_w) begin
               errors++;
               $display("FAIL load_data addr=%h: got %h, required %h", addr, cpu_data_o, exp_w);
            end
         end
      end
      @(posedge clk_i); #1;
      cpu_req_i = 1'b0; cpu_we_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
      mem_ack_i = 1'b0; mem_data_i = '0;
      repeat (2) @(negedge clk_i);
      checks++;
      if ({cpu_stall_o, mem_req_o, mem_we_o} !== 3'b000 || cpu_data_o !== 32'd0 ||
          mem_addr_o !== 32'd0 || mem_data_o !== 256'd0) begin
         errors++;
         $display("FAIL reset_outputs: stall=%0b req=%0b we=%0b addr=%h data_o=%h, required all zero",
                  cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, cpu_data_o);
      end
      rst_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_clean_miss();
      logic [255:0] l;
      l = pat_line(32'h40);
      l[2*32 +: 32] = 32'hDEAD_BEEF;
      mem_model[32'h40] = l;
      exp_mem_q.push_back(txn(1'b0, 32'h40, 0, 32'h0));
      exp_load_q.push_back(32'hDEAD_BEEF);
      do_access(1'b0, 32'h48, 32'h0, 4, 5);
      exp_load_q.push_back(32'hA5A5_0044);
      do_access(1'b0, 32'h44, 32'h0, 4, 0);
   endtask

   task automatic test_store_hit();
      do_access(1'b1, 32'h48, 32'h1234_5678, 4, 0);
      exp_load_q.push_back(32'h1234_5678);
      do_access(1'b0, 32'h48, 32'h0, 4, 0);
   endtask

   task automatic test_dirty_miss();
      exp_mem_q.push_back(txn(1'b1, 32'h40, 2, 32'h1234_5678));
      exp_mem_q.push_back(txn(1'b0, 32'h240, 0, 32'h0));
      exp_load_q.push_back(32'hA5A5_0248);
      do_access(1'b0, 32'h248, 32'h0, 4, 9);
   endtask

   task automatic test_back_to_back();
      for (int w = 0; w < 8; w++) begin
         exp_load_q.push_back((32'h240 + 32'(w * 4)) ^ 32'hA5A5_0000);
         do_access(1'b0, 32'h240 + 32'(w * 4), 32'h0, 4, 0);
      end
   endtask

   task automatic test_store_miss();
      exp_mem_q.push_back(txn(1'b0, 32'h80, 0, 32'h0));
      do_access(1'b1, 32'h80, 32'hCAFE_F00D, 3, 4);
      exp_load_q.push_back(32'hCAFE_F00D);
      do_access(1'b0, 32'h80, 32'h0, 3, 0);
      checks++;
      if (exp_mem_q.size() != 0) begin
         errors++;
         $display("FAIL pending_txn: got %0d outstanding, required 0", exp_mem_q.size());
      end
   endtask

   task automatic test_stray_ack();
      mem_data_i = '1;
      mem_ack_i  = 1'b1;
      @(posedge clk_i); #1;
      mem_ack_i  = 1'b0;
      @(negedge clk_i);
      checks++;
      if (mem_req_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
         errors++;
         $display("FAIL stray_ack: req=%0b stall=%0b, required 0 0", mem_req_o, cpu_stall_o);
      end
      @(posedge clk_i); #1;
      exp_load_q.push_back(32'hCAFE_F00D);
      do_access(1'b0, 32'h80, 32'h0, 3, 0);
      exp_load_q.push_back(32'hA5A5_024C);
      do_access(1'b0, 32'h24C, 32'h0, 3, 0);
   endtask

   task automatic test_reset_mid_wb();
      cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h480;
      @(negedge clk_i);
      checks++;
      if (cpu_stall_o !== 1'b1 || mem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL wb_detect: stall=%0b req=%0b, required 1 0", cpu_stall_o, mem_req_o);
      end
      @(negedge clk_i);
      checks++;
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h80 || mem_data_o[31:0] !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL wb_start: req=%0b we=%0b addr=%h word0=%h, required 1 1 00000080 cafef00d",
                  mem_req_o, mem_we_o, mem_addr_o, mem_data_o[31:0]);
      end
      #2;
      rst_i = 1'b1; cpu_req_i = 1'b0;
      #1;
      checks++;
      if (mem_req_o !== 1'b0 || cpu_stall_o !== 1'b0 || mem_we_o !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: req=%0b stall=%0b we=%0b, required 0 0 0", mem_req_o, cpu_stall_o, mem_we_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      // The unflushed store is gone; memory still holds the original line.
      exp_mem_q.push_back(txn(1'b0, 32'h80, 0, 32'h0));
      exp_load_q.push_back(32'hA5A5_0080);
      do_access(1'b0, 32'h80, 32'h0, 2, 3);
   endtask

   initial begin
      test_reset();
      test_clean_miss();
      test_store_hit();
      test_dirty_miss();
      test_back_to_back();
      test_store_miss();
      test_stray_ack();
      test_reset_mid_wb();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
